seven_seg_capture: RTL

- Receive-side counterpart of the stopwatch's multiplexed 7-segment driver.
- Samples the 8-bit segment bus and waits for each digit to settle. Decodes active-low segment patterns back to hex nibbles and reassembles the displayed byte, MSB digit first, then LSB digit.
- Used as an on-chip loopback checker and as the bench scoreboard front-end for display outputs.

---
 rtl/seven_seg_capture.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
//
// Receive side of a multiplexed 7-segment display driver. The segment bus is
// sampled, each shown digit has to sit still for STABLE_CYCLES samples before
// it is accepted, and the active-low glyph is decoded back to a hex nibble. An
// MSB digit followed by an LSB digit forms one frame, emitted as a byte.
//
// Parameters
//   STABLE_CYCLES   identical consecutive samples needed to accept a digit
//                   (2..255)
//   TIMEOUT_CYCLES  cycles without an accepted digit before stale asserts
//                   (power of two, >= 16)
//
// Ports
//   CLK         system clock
//   RST         synchronous reset, active-high
//   seg_in      [6:0] segments a..g active-low (bit0 = a), [7] digit select
//               (0 = MSB digit shown, 1 = LSB digit shown)
//   dout        last assembled byte {msb nibble, lsb nibble}
//   dout_valid  one-cycle pulse when dout updates
//   dout_err    set when either nibble of the frame was not a hex glyph
//   stale       level, no digit accepted for TIMEOUT_CYCLES cycles
//   frame_cnt   number of frames emitted, wraps 255 -> 0
// -----------------------------------------------------------------------------
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] seg_in,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_err,
  output logic       stale,
  output logic [7:0] frame_cnt
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]      RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]      RUN_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HAVE_MSB
  } state_t;

  state_t        state;
  logic [7:0]    d1;
  logic [7:0]    d2;
  logic [7:0]    run;
  logic [TW-1:0] tcnt;
  logic [3:0]    msb_nib;
  logic          msb_inv;

  logic          accept;
  logic [3:0]    nib;
  logic          inv;

  // Returns {invalid, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    // NOTE: the default arm covers every unlisted pattern, so the result is
    // fully specified on all paths and no latch can be inferred.
    case (pat)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  // Accept exactly on the step from STABLE_CYCLES-1 to STABLE_CYCLES; the run
  // counter then saturates, so a held digit is never accepted twice.
  assign accept     = (d1 == d2) && (run == RUN_LAST);
  assign {inv, nib} = decode(~d2[6:0]);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see this edge's values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      d1         <= '0;
      d2         <= '0;
      run        <= '0;
      tcnt       <= '0;
      state      <= IDLE;
      msb_nib    <= '0;
      msb_inv    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_err   <= 1'b0;
      stale      <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      d1 <= seg_in;
      d2 <= d1;

      if (d1 != d2) begin
        run <= '0;
      end else if (run != RUN_MAX) begin
        run <= run + 8'd1;
      end

      dout_valid <= 1'b0;

      if (accept) begin
        // An accept always restarts the timeout, even when it coincides
        // with the timeout firing.
        tcnt <= '0;
        if (!d2[7]) begin
          // MSB digit: latch it, overwriting any earlier unpaired MSB.
          msb_nib <= nib;
          msb_inv <= inv;
          state   <= HAVE_MSB;
        end else if (state == HAVE_MSB) begin
          dout       <= {msb_nib, nib};
          dout_err   <= msb_inv | inv;
          dout_valid <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          stale      <= 1'b0;
          state      <= IDLE;
        end
        // An LSB digit with no MSB held is dropped.
      end else if (tcnt == T_LAST) begin
        // Counter parks here until the next accept; the held MSB is dropped.
        stale <= 1'b1;
        state <= IDLE;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule
